axi_stream_rx: RTL and testbench

AXI-Stream slave front end of the histogram IP. It accepts the incoming pixel stream and buffers it in a 2-entry skid buffer, so the upstream master sees a fully registered tready. It forwards pixels to the histogram block over a valid/ready interface. It also counts pixels per frame and checks tlast placement against the configured frame size, pulsing frame-done and framing-error flags.

---
 rtl/axi_stream_rx.sv | 174 +++++++++++++++++
 tb/tb_axi_stream_rx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_rx.sv
// -----------------------------------------------------------------------------
// axi_stream_rx
//
// AXI-Stream slave front end of the histogram IP. Incoming pixels pass through
// a 2-entry skid buffer, which lets s_tready come straight from a flop, and are
// forwarded to the histogram block over a valid/ready interface. On every
// delivered pixel the block checks where tlast falls relative to the configured
// frame size, and pulses frame-done and framing-error flags.
//
// Ports:
//   aclk, areset          clock (rising edge), asynchronous active-high reset
//   s_tdata/tvalid/tlast  AXI-Stream beat from the upstream master
//   s_tready              AXI-Stream ready, registered
//   pix_data_o/last_o     beat presented to the histogram block
//   pix_valid_o           pixel valid (registered)
//   pix_ready_i           histogram block accepts the pixel
//   pixel_count_o         pixels delivered so far in the current frame
//   frame_done_o          1-cycle pulse when a frame is closed
//   err_early_last_o      1-cycle pulse: tlast before P_FRAME_PIXELS pixels
//   err_missing_last_o    1-cycle pulse: P_FRAME_PIXELS-th pixel without tlast
// -----------------------------------------------------------------------------
module axi_stream_rx #(
    parameter int P_DW           = 8,
    parameter int P_FRAME_PIXELS = 1024,
    parameter int P_CW           = 16
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [P_DW-1:0] s_tdata,
    input  logic            s_tvalid,
    input  logic            s_tlast,
    output logic            s_tready,
    output logic [P_DW-1:0] pix_data_o,
    output logic            pix_valid_o,
    output logic            pix_last_o,
    input  logic            pix_ready_i,
    output logic [P_CW-1:0] pixel_count_o,
    output logic            frame_done_o,
    output logic            err_early_last_o,
    output logic            err_missing_last_o
);

    localparam logic [P_CW-1:0] LP_FRAME_PIXELS = P_CW'(P_FRAME_PIXELS);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } buf_state_t;

    buf_state_t      state_q;
    buf_state_t      state_d;
    logic            load_main_in;    // main register takes the incoming beat
    logic            load_skid_in;    // skid register takes the incoming beat
    logic            load_main_skid;  // skid register drains into main
    logic [P_DW-1:0] skid_data_q;
    logic            skid_last_q;
    logic            accept;
    logic            deliver;
    logic [P_CW-1:0] pix_index;       // 1-based index of the pixel being delivered

    assign accept    = s_tvalid & s_tready;
    assign deliver   = pix_valid_o & pix_ready_i;
    assign pix_index = pixel_count_o + P_CW'(1);

    // -------------------------------------------------------------------------
    // Buffer control
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d      = ST_FULL;
                    load_skid_in = 1'b1;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // s_tready is low here, so only a delivery can happen.
                if (deliver) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Ready and valid are decoded from the next state and registered, so both
    // interfaces see clean flop outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_EMPTY;
            s_tready    <= 1'b1;
            pix_valid_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_tready    <= (state_d != ST_FULL);
            pix_valid_o <= (state_d != ST_EMPTY);
        end
    end

    // NOTE: the data registers are reset as well because pix_data_o and
    // pix_last_o must read zero out of reset; the skid entry follows suit so
    // the datapath has a single, uniform reset behaviour.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pix_data_o  <= '0;
            pix_last_o  <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            if (load_main_in) begin
                pix_data_o <= s_tdata;
                pix_last_o <= s_tlast;
            end else if (load_main_skid) begin
                pix_data_o <= skid_data_q;
                pix_last_o <= skid_last_q;
            end
            if (load_skid_in) begin
                skid_data_q <= s_tdata;
                skid_last_q <= s_tlast;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame checking: evaluated on every delivered pixel. A frame closes on
    // tlast or on the last expected pixel, whichever comes first, so the
    // counter never exceeds P_FRAME_PIXELS-1.
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pixel_count_o      <= '0;
            frame_done_o       <= 1'b0;
            err_early_last_o   <= 1'b0;
            err_missing_last_o <= 1'b0;
        end else begin
            frame_done_o       <= 1'b0;
            err_early_last_o   <= 1'b0;
            err_missing_last_o <= 1'b0;
            if (deliver) begin
                if (pix_last_o || (pix_index == LP_FRAME_PIXELS)) begin
                    pixel_count_o      <= '0;
                    frame_done_o       <= 1'b1;
                    // pix_index cannot exceed the frame size, so "not equal"
                    // means the tlast arrived early.
                    err_early_last_o   <= pix_last_o && (pix_index != LP_FRAME_PIXELS);
                    err_missing_last_o <= !pix_last_o;
                end else begin
                    pixel_count_o <= pix_index;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_rx.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_rx
//
// Self-checking bench for axi_stream_rx. A reference model (a queue of accepted
// beats plus a per-frame pixel counter) runs on the falling edge alongside the
// stimulus, and is compared against the DUT's outputs on every cycle. Directed
// frame tests, a table of handshake vectors and a mid-frame reset sequence
// drive the DUT.
// -----------------------------------------------------------------------------
module tb_axi_stream_rx;

    localparam int P_DW           = 8;
    localparam int P_FRAME_PIXELS = 1024;
    localparam int P_CW           = 16;

    logic            aclk = 1'b0;
    logic            areset;
    logic [P_DW-1:0] s_tdata;
    logic            s_tvalid;
    logic            s_tlast;
    logic            s_tready;
    logic [P_DW-1:0] pix_data_o;
    logic            pix_valid_o;
    logic            pix_last_o;
    logic            pix_ready_i;
    logic [P_CW-1:0] pixel_count_o;
    logic            frame_done_o;
    logic            err_early_last_o;
    logic            err_missing_last_o;

    always #5 aclk = ~aclk;

    axi_stream_rx #(
        .P_DW           (P_DW),
        .P_FRAME_PIXELS (P_FRAME_PIXELS),
        .P_CW           (P_CW)
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_tdata            (s_tdata),
        .s_tvalid           (s_tvalid),
        .s_tlast            (s_tlast),
        .s_tready           (s_tready),
        .pix_data_o         (pix_data_o),
        .pix_valid_o        (pix_valid_o),
        .pix_last_o         (pix_last_o),
        .pix_ready_i        (pix_ready_i),
        .pixel_count_o      (pixel_count_o),
        .frame_done_o       (frame_done_o),
        .err_early_last_o   (err_early_last_o),
        .err_missing_last_o (err_missing_last_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: beats in flight are a FIFO of accepted beats; ready is
    // "fewer than two in flight", valid is "at least one in flight".
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic            last;
        logic [P_DW-1:0] data;
    } beat_t;

    beat_t mq[$];
    beat_t m_b;
    int    m_occ;
    int    m_cnt     = 0;
    logic  exp_done  = 1'b0;
    logic  exp_early = 1'b0;
    logic  exp_miss  = 1'b0;
    int    n_done    = 0;
    int    n_early   = 0;
    int    n_miss    = 0;
    int    n_deliv   = 0;
    int    n_stall   = 0;

    always @(negedge aclk) begin
        if (areset) begin
            mq.delete();
            m_cnt     = 0;
            exp_done  = 1'b0;
            exp_early = 1'b0;
            exp_miss  = 1'b0;
            check("rst_tready", s_tready, 1);
            check("rst_valid", pix_valid_o, 0);
            check("rst_data", pix_data_o, 0);
            check("rst_count", pixel_count_o, 0);
            check("rst_pulses", {err_missing_last_o, err_early_last_o, frame_done_o}, 0);
        end else begin
            m_occ = mq.size();
            check("s_tready", s_tready, m_occ < 2);
            check("pix_valid", pix_valid_o, m_occ > 0);
            if (m_occ > 0) begin
                check("pix_data", pix_data_o, mq[0].data);
                check("pix_last", pix_last_o, mq[0].last);
            end
            check("pixel_count", pixel_count_o, m_cnt);
            check("frame_done", frame_done_o, exp_done);
            check("err_early", err_early_last_o, exp_early);
            check("err_missing", err_missing_last_o, exp_miss);

            n_done  += int'(frame_done_o);
            n_early += int'(err_early_last_o);
            n_miss  += int'(err_missing_last_o);
            if (!s_tready) n_stall++;

            // Events that the upcoming rising edge will see.
            exp_done  = 1'b0;
            exp_early = 1'b0;
            exp_miss  = 1'b0;
            if (pix_valid_o && pix_ready_i && m_occ > 0) begin
                m_b = mq.pop_front();
                n_deliv++;
                if (m_b.last || (m_cnt + 1 == P_FRAME_PIXELS)) begin
                    exp_done  = 1'b1;
                    exp_early = m_b.last && (m_cnt + 1 < P_FRAME_PIXELS);
                    exp_miss  = !m_b.last;
                    m_cnt     = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (s_tvalid && s_tready) mq.push_back({s_tlast, s_tdata});
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic do_reset();
        areset      = 1'b1;
        s_tvalid    = 1'b0;
        pix_ready_i = 1'b0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    // mode 0: always ready, no gaps; mode 1: ready 1-on/2-off, random gaps;
    // mode 2: random ready, random gaps. tlast on every last_at-th beat.
    task automatic run_stream(input int nbeats, input int last_at, input int mode,
                              input logic [7:0] off);
        int   idx    = 0;
        int   cyc    = 0;
        int   budget = nbeats * 12 + 200;
        logic acc;
        s_tvalid = 1'b0;
        while (idx < nbeats && cyc < budget) begin
            case (mode)
                0:       pix_ready_i = 1'b1;
                1:       pix_ready_i = (cyc % 3 == 0);
                default: pix_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (!s_tvalid) begin
                s_tvalid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                s_tdata  = 8'(idx) + off;
                s_tlast  = (last_at > 0) && ((idx + 1) % last_at == 0);
            end
            acc = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
            cyc++;
            if (acc) begin
                idx++;
                s_tvalid = 1'b0;
            end
        end
        s_tvalid = 1'b0;
        check("beats_sent", idx, nbeats);
        pix_ready_i = 1'b1;
        cyc = 0;
        while (mq.size() != 0 && cyc < 20) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        repeat (2) @(posedge aclk);
        #1;
        check("drained", mq.size(), 0);
    endtask

    task automatic frame_test(input string tag, input int nbeats, input int last_at,
                              input int mode, input int e_done, input int e_early,
                              input int e_miss, input int e_count);
        int d0 = n_done;
        int e0 = n_early;
        int m0 = n_miss;
        int v0 = n_deliv;
        run_stream(nbeats, last_at, mode, 8'($urandom_range(0, 255)));
        check({tag, "_done"}, n_done - d0, e_done);
        check({tag, "_early"}, n_early - e0, e_early);
        check({tag, "_missing"}, n_miss - m0, e_miss);
        check({tag, "_delivered"}, n_deliv - v0, nbeats);
        check({tag, "_count"}, pixel_count_o, e_count);
    endtask

    // Handshake vectors: inputs applied before an edge, outputs expected after.
    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       rdy;
        logic       e_tready;
        logic       e_valid;
        logic [7:0] e_data;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int s0;
        int d0;

        areset      = 1'b1;
        s_tvalid    = 1'b0;
        s_tdata     = '0;
        s_tlast     = 1'b0;
        pix_ready_i = 1'b0;
        do_reset();

        // Full frame, no back-pressure.
        frame_test("t1", 1024, 1024, 0, 1, 0, 0, 0);

        // Full frame with 1-on/2-off ready and random input gaps.
        s0 = n_stall;
        frame_test("t2", 1024, 1024, 1, 1, 0, 0, 0);
        check("t2_stalled", (n_stall - s0) > 0, 1);

        // Early tlast, then a clean frame.
        frame_test("t3a", 10, 10, 0, 1, 1, 0, 0);
        frame_test("t3b", 1024, 1024, 0, 1, 0, 0, 0);

        // Every pixel carries tlast: back-to-back closures.
        frame_test("b2b", 5, 1, 0, 5, 5, 0, 0);

        // Two frames under random ready and gaps.
        frame_test("rnd", 2048, 1024, 2, 2, 0, 0, 0);

        // Missing tlast: frame closes on pixel 1024, six pixels carry over.
        frame_test("t4", 1030, 0, 0, 1, 0, 1, 6);

        // Skid buffer behaviour under a stalled consumer.
        tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1};
        tbl[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1};
        tbl[2] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1};
        tbl[3] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1};
        tbl[4] = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2};
        tbl[5] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA2};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        for (int i = 0; i < 8; i++) begin
            s_tvalid    = tbl[i].vld;
            s_tdata     = tbl[i].data;
            s_tlast     = 1'b0;
            pix_ready_i = tbl[i].rdy;
            @(posedge aclk);
            #1;
            check($sformatf("t5_tready[%0d]", i), s_tready, tbl[i].e_tready);
            check($sformatf("t5_valid[%0d]", i), pix_valid_o, tbl[i].e_valid);
            if (tbl[i].e_valid) check($sformatf("t5_data[%0d]", i), pix_data_o, tbl[i].e_data);
        end
        s_tvalid = 1'b0;

        // Mid-frame reset with the buffer full.
        do_reset();
        run_stream(500, 0, 0, 8'h00);
        check("t6_count500", pixel_count_o, 500);
        pix_ready_i = 1'b0;
        s_tvalid    = 1'b1;
        s_tdata     = 8'h55;
        s_tlast     = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("t6_full_tready", s_tready, 0);
        check("t6_full_valid", pix_valid_o, 1);
        check("t6_full_count", pixel_count_o, 500);
        d0       = n_done + n_early + n_miss;
        areset   = 1'b1;
        s_tvalid = 1'b0;
        #1;
        check("t6_rst_valid", pix_valid_o, 0);
        check("t6_rst_tready", s_tready, 1);
        check("t6_rst_count", pixel_count_o, 0);
        check("t6_rst_pulses", {err_missing_last_o, err_early_last_o, frame_done_o}, 0);
        @(posedge aclk);
        #1 areset = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("t6_no_pulses", n_done + n_early + n_miss - d0, 0);
        frame_test("t6b", 1024, 1024, 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
